// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: consumes the EX/MEM buffer, runs loads/stores as
// req/ack transactions on the data-memory port, stalls upstream while an
// access is outstanding, and registers the write-back fields into MEM/WB.
module mem_stage_ctrl #(
   parameter int DW      = 16,
   parameter int RW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          regWrite_i,
   input  logic          r0Write_i,
   input  logic          memRead_i,
   input  logic          memWrite_i,
   input  logic          memSource_i,
   input  logic [RW-1:0] RA1_i,
   input  logic [DW-1:0] ALUResult_i,
   input  logic [DW-1:0] DataIn_i,
   input  logic [DW-1:0] R0D_i,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          stall,
   output logic          mem_err,
   output logic          regWrite_o,
   output logic          r0Write_o,
   output logic [RW-1:0] RA1_o,
   output logic [DW-1:0] WBData_o,
   output logic [DW-1:0] R0D_o
);

   // Counter only ever counts up to TIMEOUT, so this width never wraps.
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic           w_memop;
   logic           w_stall;
   logic           w_timeout;

   logic [CW-1:0]  r_cnt;
   logic           r_regWrite;
   logic           r_r0Write;
   logic [RW-1:0]  r_RA1;
   logic [DW-1:0]  r_R0D;
   logic [DW-1:0]  r_aluRes;
   logic           r_memSource;
   logic           r_isRead;
   logic [DW-1:0]  r_rdata;
   logic           r_abort;

   logic           r_memReq;
   logic           r_memWe;
   logic [DW-1:0]  r_memAddr;
   logic [DW-1:0]  r_memWdata;
   logic           r_memErr;
   logic           r_regWriteO;
   logic           r_r0WriteO;
   logic [RW-1:0]  r_RA1O;
   logic [DW-1:0]  r_WBDataO;
   logic [DW-1:0]  r_R0DO;

   assign w_memop = memRead_i | memWrite_i;

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic plus the stall and timeout decisions.
   always_comb begin
      w_nextState = r_state;
      w_stall     = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_memop) begin
               w_stall     = 1'b1;
               w_nextState = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_stall = 1'b1;
            if (mem_ack) begin
               w_nextState = S_DONE;
            end else if (r_cnt == LAST_WAIT) begin
               w_timeout   = 1'b1;
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Stall is forced low while reset is asserted so upstream is not frozen.
   assign stall = reset & w_stall;

   // Datapath: latch the instruction, drive the memory port, load MEM/WB.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt       <= '0;
         r_regWrite  <= 1'b0;
         r_r0Write   <= 1'b0;
         r_RA1       <= '0;
         r_R0D       <= '0;
         r_aluRes    <= '0;
         r_memSource <= 1'b0;
         r_isRead    <= 1'b0;
         r_rdata     <= '0;
         r_abort     <= 1'b0;
         r_memReq    <= 1'b0;
         r_memWe     <= 1'b0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
         r_memErr    <= 1'b0;
         r_regWriteO <= 1'b0;
         r_r0WriteO  <= 1'b0;
         r_RA1O      <= '0;
         r_WBDataO   <= '0;
         r_R0DO      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_memop) begin
                  r_regWrite  <= regWrite_i;
                  r_r0Write   <= r0Write_i;
                  r_RA1       <= RA1_i;
                  r_R0D       <= R0D_i;
                  r_aluRes    <= ALUResult_i;
                  r_memSource <= memSource_i;
                  r_isRead    <= memRead_i & ~memWrite_i;
                  r_abort     <= 1'b0;
                  r_cnt       <= '0;
                  r_memAddr   <= ALUResult_i;
                  r_memWdata  <= DataIn_i;
                  r_memWe     <= memWrite_i;
                  r_memReq    <= 1'b1;
                  r_regWriteO <= 1'b0;
                  r_r0WriteO  <= 1'b0;
               end else begin
                  r_regWriteO <= regWrite_i;
                  r_r0WriteO  <= r0Write_i;
                  r_RA1O      <= RA1_i;
                  r_R0DO      <= R0D_i;
                  r_WBDataO   <= ALUResult_i;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + CW'(1);
               if (mem_ack) begin
                  r_rdata  <= mem_rdata;
                  r_memReq <= 1'b0;
               end else if (w_timeout) begin
                  r_memErr <= 1'b1;
                  r_memReq <= 1'b0;
                  r_abort  <= 1'b1;
               end
            end
            S_DONE: begin
               r_RA1O <= r_RA1;
               r_R0DO <= r_R0D;
               if (r_abort) begin
                  r_regWriteO <= 1'b0;
                  r_r0WriteO  <= 1'b0;
                  r_WBDataO   <= '0;
               end else begin
                  r_regWriteO <= r_regWrite;
                  r_r0WriteO  <= r_r0Write;
                  r_WBDataO   <= (r_memSource && r_isRead) ? r_rdata : r_aluRes;
               end
            end
            default: begin
               r_memReq <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req    = r_memReq;
   assign mem_we     = r_memWe;
   assign mem_addr   = r_memAddr;
   assign mem_wdata  = r_memWdata;
   assign mem_err    = r_memErr;
   assign regWrite_o = r_regWriteO;
   assign r0Write_o  = r_r0WriteO;
   assign RA1_o      = r_RA1O;
   assign WBData_o   = r_WBDataO;
   assign R0D_o      = r_R0DO;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller on the consumer side of the EX/MEM pipeline buffer in the 16-bit datapath.
- Takes the buffered EX/MEM control and data fields and runs each load/store as a req/ack transaction on the data-memory port.
- Stalls upstream stages while an access is outstanding.
- Registers the write-back fields into the MEM/WB stage. Non-memory instructions pass through with 1-cycle latency.

Parameters:
DW, 16, data/address width
RW, 4, register-address width (RA1)
TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
regWrite_i  in  1  EX/MEM register-file write enable
r0Write_i  in  1  EX/MEM R0 write enable
memRead_i  in  1  load request
memWrite_i  in  1  store request
memSource_i  in  1  write-back select: 1 = memory data, 0 = ALU result
RA1_i  in  RW  destination register address
ALUResult_i  in  DW  ALU result / memory address
DataIn_i  in  DW  store data
R0D_i  in  DW  R0 write data
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  DW  memory address
mem_wdata  out  DW  store data
mem_rdata  in  DW  load data, valid when mem_ack=1
mem_ack  in  1  memory completion strobe
stall  out  1  freeze EX/MEM buffer and earlier stages
mem_err  out  1  sticky timeout flag
regWrite_o  out  1  MEM/WB register write enable
r0Write_o  out  1  MEM/WB R0 write enable
RA1_o  out  RW  MEM/WB destination address
WBData_o  out  DW  MEM/WB write-back data
R0D_o  out  DW  MEM/WB R0 data

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE; timeout counter=0.
  - All outputs 0, including mem_err.
  - Any in-flight access is abandoned; mem_req drops the next cycle.
- States: IDLE, ACCESS, DONE.
- memop = memRead_i | memWrite_i. If both are set, the op is a write; the read is ignored.
- IDLE, memop=0:
  - MEM/WB outputs load at the edge: regWrite_o=regWrite_i, r0Write_o=r0Write_i, RA1_o=RA1_i, R0D_o=R0D_i, WBData_o=ALUResult_i.
  - stall=0. Latency 1 cycle.
- IDLE, memop=1:
  - stall=1 combinationally in this cycle.
  - At the edge, latch the instruction fields. Load mem_addr=ALUResult_i, mem_wdata=DataIn_i, mem_we=memWrite_i, mem_req=1.
  - Clear the counter and go to ACCESS.
  - MEM/WB enables regWrite_o and r0Write_o are written 0 (bubble).
- ACCESS:
  - stall=1; mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - Inputs are ignored.
  - regWrite_o and r0Write_o stay 0.
  - Counter increments each cycle.
  - mem_ack=1 sampled: latch mem_rdata, drop mem_req at the edge, go to DONE.
  - Counter reaches TIMEOUT with no ack: set mem_err (sticky until reset), drop mem_req, flag abort, go to DONE.
- DONE:
  - stall=0, so upstream advances at this edge.
  - At the edge, load MEM/WB outputs from the latched fields, then return to IDLE.
  - WBData_o = latched rdata if memSource=1 and the op was a read; otherwise the latched ALUResult.
  - Store: regWrite_o/r0Write_o take the latched values (normally 0).
  - Abort: regWrite_o=0, r0Write_o=0, WBData_o=0.
- Minimum load/store latency: request edge, then ack cycle, then DONE cycle. With ack on the first ACCESS cycle, the instruction is stalled 2 cycles.
- mem_ack while in IDLE or DONE is ignored; a late ack after abort is ignored.
- memSource_i=1 without memRead_i: WBData_o = ALUResult.
- Counter width is sized for TIMEOUT and does not wrap.

Test Plan:
1. Reset held low 2 cycles with all inputs nonzero → all outputs 0, stall=0, mem_req=0. Release, then ALU op regWrite_i=1, RA1_i=7, ALUResult_i=8 → next edge regWrite_o=1, RA1_o=7, WBData_o=8, stall never 1.
2. Load memRead_i=1, memSource_i=1, regWrite_i=1, ALUResult_i=16'h0040, RA1_i=3; mem_ack=1 with mem_rdata=16'hBEEF 2 cycles after req → mem_addr=16'h0040, mem_we=0, stall=1 for 3 cycles, then regWrite_o=1, RA1_o=3, WBData_o=16'hBEEF.
3. Store memWrite_i=1, ALUResult_i=16'h0010, DataIn_i=9; ack on first ACCESS cycle → mem_we=1, mem_wdata=9, mem_req for exactly 1 cycle, regWrite_o=0 throughout.
4. Load with mem_ack held 0 and TIMEOUT=15 → mem_req drops after 15 ACCESS cycles, mem_err=1 and stays 1; regWrite_o=0, WBData_o=0; a later ack pulse in IDLE has no effect.
5. memRead_i=memWrite_i=1 → treated as a write (mem_we=1). Separately, reset=0 mid-ACCESS → next cycle mem_req=0, stall=0, state IDLE, mem_err=0.
